uart_fifo_fwft: RTL and testbench

Parametrised first-word-fall-through FIFO built on an inferred single-port-write, asynchronous-read storage array. It buffers bytes between the UART receiver/transmitter and the bus interface, with zero-cycle read access to the head entry. It adds occupancy count, programmable almost-full/almost-empty thresholds and optional sticky error flags. Storage is a plain register array, so it infers as distributed RAM. It is never reset.

---
 rtl/uart_fifo_fwft_if.sv | 29 ++
 rtl/uart_fifo_fwft.sv | 60 ++++++
 tb/tb_uart_fifo_fwft.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_fifo_fwft_if.sv
// uart_fifo_fwft_if: push/pop bus for the FWFT FIFO; error signals exist only with UART_FIFO_ERR_EN
interface uart_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
`ifdef UART_FIFO_ERR_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;
  modport master (output wr_en, din, rd_en, err_clr,
                  input dout, empty, full, almost_full, almost_empty, count, overflow, underflow);
  modport slave (input wr_en, din, rd_en, err_clr,
                 output dout, empty, full, almost_full, almost_empty, count, overflow, underflow);
`else
  modport master (output wr_en, din, rd_en,
                  input dout, empty, full, almost_full, almost_empty, count);
  modport slave (input wr_en, din, rd_en,
                 output dout, empty, full, almost_full, almost_empty, count);
`endif
endinterface

// File: rtl/uart_fifo_fwft.sv
// uart_fifo_fwft: first-word-fall-through byte FIFO with count and thresholds; define UART_FIFO_ERR_EN for sticky overflow/underflow flags
module uart_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic             clk,
  input logic             rst_n,
  uart_fifo_fwft_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (ADDR_WIDTH+1)'(DEPTH);
  assign w_push  = bus.wr_en && !w_full;
  assign w_pop   = bus.rd_en && !w_empty;
  // storage is never reset; writes are suppressed while reset is asserted
  always_ff @(posedge clk)
    if (rst_n && w_push) r_mem[r_wr_ptr] <= bus.din;
  // pointers wrap naturally; count tracks net push minus pop
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);
    end
  assign bus.dout         = r_mem[r_rd_ptr];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.count        = r_count;
  assign bus.almost_full  = r_count >= (ADDR_WIDTH+1)'(AF_LEVEL);
  assign bus.almost_empty = r_count <= (ADDR_WIDTH+1)'(AE_LEVEL);
`ifdef UART_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;
  // sticky error flags; a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.wr_en && w_full) || (r_overflow && !bus.err_clr);
      r_underflow <= (bus.rd_en && w_empty) || (r_underflow && !bus.err_clr);
    end
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_uart_fifo_fwft.sv
// tb_uart_fifo_fwft: directed self-checking bench for uart_fifo_fwft (DEPTH=4, AF=3, AE=1)
module tb_uart_fifo_fwft;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  uart_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();
  uart_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.din = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din = '0;
`ifdef UART_FIFO_ERR_EN
    bus.err_clr = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_af", bus.almost_full, 0);
`ifdef UART_FIFO_ERR_EN
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);
`endif
    push(8'hA1);
    chk("a1_empty", bus.empty, 0);
    chk("a1_count", bus.count, 1);
    chk("a1_dout", bus.dout, 8'hA1);
    chk("a1_ae", bus.almost_empty, 1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("a1_pop_empty", bus.empty, 1);
    push(8'h11);
    push(8'h22);
    chk("c2_ae", bus.almost_empty, 0);
    chk("c2_af", bus.almost_full, 0);
    push(8'h33);
    chk("c3_af", bus.almost_full, 1);
    chk("c3_full", bus.full, 0);
    push(8'h44);
    chk("c4_full", bus.full, 1);
    chk("c4_count", bus.count, 4);
    push(8'h55);
    chk("ovf_count", bus.count, 4);
    chk("ovf_dout", bus.dout, 8'h11);
`ifdef UART_FIFO_ERR_EN
    chk("ovf_flag", bus.overflow, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_dout", i), bus.dout, 8'h11 * (i + 1));
      bus.rd_en = 1'b1;
      tick();
    end
    bus.rd_en = 1'b0;
    chk("drain_empty", bus.empty, 1);
    chk("drain_count", bus.count, 0);
    push(8'hF0);
    push(8'hF1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_dout", i), bus.dout, i == 0 ? 8'hF0 : i == 1 ? 8'hF1 : i - 2);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din = 8'(i);
      tick();
      chk($sformatf("hold%0d_count", i), bus.count, 2);
    end
    bus.wr_en = 1'b0;
    chk("tail0_dout", bus.dout, 8'h08);
    tick();
    chk("tail1_dout", bus.dout, 8'h09);
    tick();
    bus.rd_en = 1'b0;
    chk("tail_empty", bus.empty, 1);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("sim_count", bus.count, 1);
    chk("sim_dout", bus.dout, 8'h5A);
`ifdef UART_FIFO_ERR_EN
    chk("sim_unf", bus.underflow, 1);
    chk("ovf_sticky", bus.overflow, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("clr_unf", bus.underflow, 0);
    chk("clr_ovf", bus.overflow, 0);
`endif
    push(8'h61);
    push(8'h62);
    chk("pre_rst_count", bus.count, 3);
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.din = 8'hEE;
    tick();
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    chk("mrst_count", bus.count, 0);
    chk("mrst_empty", bus.empty, 1);
    chk("mrst_full", bus.full, 0);
    chk("mrst_af", bus.almost_full, 0);
    chk("mrst_ae", bus.almost_empty, 1);
    push(8'h77);
    chk("post_dout", bus.dout, 8'h77);
    chk("post_count", bus.count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
